// File: rtl/registers_pkg.sv
// Shared types for the register bank: register/index types, inc/dec step encoding
// and the helper that turns a step select into its numeric step.
package registers_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_NUM_REGS    = 16;
    localparam int DEFAULT_INDEX_WIDTH = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_DATA_WIDTH-1:0]  t_reg;
    typedef logic [DEFAULT_INDEX_WIDTH-1:0] t_reg_index;

    typedef enum logic [1:0] {
        BYTE     = 2'b00,
        WORD     = 2'b01,
        LONG     = 2'b10,
        RESERVED = 2'b11
    } t_incdec_size;

    // RESERVED maps to a zero step; callers also treat it as "no operation".
    function automatic logic [2:0] incdec_step(input t_incdec_size size);
        logic [2:0] step;
        case (size)
            BYTE:    step = 3'd1;
            WORD:    step = 3'd2;
            LONG:    step = 3'd4;
            default: step = 3'd0;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/register_incdec.sv
// Combinational increment/decrement of one register value with carry/borrow flag.
// active is high only when exactly one of inc/dec is set and the size is not reserved.
module register_incdec
    import registers_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  inc,
    input  logic                  dec,
    input  t_incdec_size          size,
    output logic [DATA_WIDTH-1:0] next_value,
    output logic                  wrap,
    output logic                  active
);

    localparam int EXT_W = DATA_WIDTH + 1;

    logic [EXT_W-1:0] ext_value;
    logic [EXT_W-1:0] ext_step;
    logic [EXT_W-1:0] result;

    // One extra bit catches the carry out of an inc and the borrow of a dec alike.
    always_comb begin
        ext_value = {1'b0, value};
        ext_step  = EXT_W'(incdec_step(size));
        active    = (inc ^ dec) && (size != RESERVED);
        result    = ext_value;
        if (active) begin
            if (inc) begin
                result = ext_value + ext_step;
            end else begin
                result = ext_value - ext_step;
            end
        end
        next_value = result[DATA_WIDTH-1:0];
        wrap       = result[DATA_WIDTH];
    end

endmodule

// File: rtl/register_bank.sv
// Register bank with one write/clear port, one inc/dec port and three combinational reads.
// Define REGISTER_BANK_BYPASS_EN to forward same-cycle write data to the read ports.
module register_bank
    import registers_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int INDEX_WIDTH = $clog2(NUM_REGS),
    parameter int ZERO_R0     = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   write,
    input  logic [INDEX_WIDTH-1:0] write_index,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   inc,
    input  logic                   dec,
    input  logic [INDEX_WIDTH-1:0] incdec_index,
    input  logic [1:0]             incdec_size,
    input  logic [INDEX_WIDTH-1:0] read_reg1_index,
    input  logic [INDEX_WIDTH-1:0] read_reg2_index,
    input  logic [INDEX_WIDTH-1:0] read_reg3_index,
    output logic [DATA_WIDTH-1:0]  read_reg1_data,
    output logic [DATA_WIDTH-1:0]  read_reg2_data,
    output logic [DATA_WIDTH-1:0]  read_reg3_data,
    output logic                   incdec_wrap
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  wc_en;
    logic [DATA_WIDTH-1:0] wc_value;
    logic [DATA_WIDTH-1:0] incdec_value;
    logic [DATA_WIDTH-1:0] incdec_next;
    logic                  incdec_carry;
    logic                  incdec_active;
    logic                  incdec_commit;

    function automatic logic is_r0_locked(input logic [INDEX_WIDTH-1:0] idx);
        return (ZERO_R0 != 0) && (idx == '0);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [INDEX_WIDTH-1:0] idx);
        logic [DATA_WIDTH-1:0] v;
`ifdef REGISTER_BANK_BYPASS_EN
        if (write && (idx == write_index)) begin
            v = wc_value;
        end else begin
            v = regs[idx];
        end
`else
        v = regs[idx];
`endif
        if (is_r0_locked(idx)) begin
            v = '0;
        end
        return v;
    endfunction

    // clear wins over write, so the write path only ever carries zero or write_data.
    always_comb begin
        wc_en        = clear | write;
        wc_value     = clear ? '0 : write_data;
        incdec_value = regs[incdec_index];
    end

    register_incdec #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_incdec (
        .value      (incdec_value),
        .inc        (inc),
        .dec        (dec),
        .size       (t_incdec_size'(incdec_size)),
        .next_value (incdec_next),
        .wrap       (incdec_carry),
        .active     (incdec_active)
    );

    // An inc/dec colliding with a write/clear on the same index is dropped entirely.
    always_comb begin
        incdec_commit = incdec_active
                        && !(wc_en && (write_index == incdec_index))
                        && !is_r0_locked(incdec_index);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            incdec_wrap <= 1'b0;
        end else begin
            if (wc_en && !is_r0_locked(write_index)) begin
                regs[write_index] <= wc_value;
            end
            if (incdec_commit) begin
                regs[incdec_index] <= incdec_next;
            end
            incdec_wrap <= incdec_commit && incdec_carry;
        end
    end

    always_comb begin
        read_reg1_data = read_port(read_reg1_index);
        read_reg2_data = read_port(read_reg2_index);
        read_reg3_data = read_port(read_reg3_index);
    end

endmodule
